// File: rtl/fpu_channel_port.sv
// FPU-side CCN endpoint: outbound send FIFO with retry, receive sequencer (register/wait/unregister),
// and a valid/ready result register. Define PERSIST_RECV_EN to honour core_recv_persist.
module fpu_channel_port #(
    parameter int TX_DEPTH       = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        core_send_valid,
    output logic        core_send_ready,
    input  logic [7:0]  core_send_chan,
    input  logic [31:0] core_send_msg,
    input  logic        core_recv_req,
    input  logic [7:0]  core_recv_chan,
    input  logic        core_recv_persist,
    input  logic        core_recv_cancel,
    output logic        core_recv_busy,
    output logic        core_rx_valid,
    input  logic        core_rx_ready,
    output logic [7:0]  core_rx_chan,
    output logic [31:0] core_rx_msg,
    output logic [1:0]  core_rx_status,
    output logic [7:0]  ccn_send_chan,
    output logic [31:0] ccn_send_msg,
    output logic        ccn_send_valid,
    input  logic        ccn_send_ready,
    input  logic [7:0]  ccn_recv_chan,
    input  logic [31:0] ccn_recv_msg,
    input  logic        ccn_recv_valid,
    output logic        ccn_recv_ready,
    output logic [7:0]  ccn_reg_chan,
    output logic        ccn_reg_valid,
    input  logic        ccn_reg_ready,
    output logic [7:0]  ccn_unreg_chan,
    output logic        ccn_unreg_valid,
    input  logic        ccn_unreg_ready,
    output logic [15:0] dbg_drop_count,
    output logic [15:0] dbg_tx_count
);
    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0] CNT_ONE = (PW+1)'(1);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_CHK} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_REG, RX_REG_CHK, RX_WAIT, RX_UNREG, RX_RESP} rx_state_t;

    logic [7:0]  tx_chan_mem [TX_DEPTH];
    logic [31:0] tx_msg_mem  [TX_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [15:0]   tx_cnt_q, drop_cnt_q;
    tx_state_t     tx_state_q, tx_state_d;
    logic          push, pop, full;

    rx_state_t   rx_state_q, rx_state_d;
    logic [7:0]  chan_q, chan_d, rx_chan_q, rx_chan_d;
    logic [31:0] rx_msg_q, rx_msg_d, timer_q, timer_d;
    logic [1:0]  status_q, status_d;
    logic        persist_q, persist_d, persist_in, captured, timeout_hit;
    logic        unused_inputs;

`ifdef PERSIST_RECV_EN
    assign persist_in = core_recv_persist;
`else
    assign persist_in = 1'b0;
`endif
    assign unused_inputs = ^{ccn_unreg_ready, core_recv_persist};

    assign full            = (count_q == DEPTH_CNT);
    assign core_send_ready = !full;
    assign push            = core_send_valid && !full;
    // Head entry is only driven while the TX FSM owns it, so idle/reset outputs read as zero.
    assign ccn_send_chan   = (tx_state_q != TX_IDLE) ? tx_chan_mem[rd_ptr_q] : 8'd0;
    assign ccn_send_msg    = (tx_state_q != TX_IDLE) ? tx_msg_mem[rd_ptr_q] : 32'd0;
    assign dbg_tx_count    = tx_cnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            tx_chan_mem[wr_ptr_q] <= core_send_chan;
            tx_msg_mem[wr_ptr_q]  <= core_send_msg;
        end
    end

    always_comb begin
        tx_state_d     = tx_state_q;
        pop            = 1'b0;
        ccn_send_valid = 1'b0;
        case (tx_state_q)
            TX_IDLE: if (count_q != '0) tx_state_d = TX_SEND;
            TX_SEND: begin
                ccn_send_valid = 1'b1;
                tx_state_d     = TX_CHK;
            end
            TX_CHK: begin
                if (ccn_send_ready) begin
                    pop        = 1'b1;
                    tx_state_d = ((count_q > CNT_ONE) || push) ? TX_SEND : TX_IDLE;
                end else begin
                    tx_state_d = TX_SEND;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
            if (pop && tx_cnt_q != 16'hFFFF) tx_cnt_q <= tx_cnt_q + 16'd1;
        end
    end

    assign captured    = (rx_state_q == RX_WAIT) && ccn_recv_valid && (ccn_recv_chan == chan_q);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TMO_LAST);

    always_comb begin
        rx_state_d = rx_state_q;
        chan_d     = chan_q;
        persist_d  = persist_q;
        timer_d    = timer_q;
        status_d   = status_q;
        rx_chan_d  = rx_chan_q;
        rx_msg_d   = rx_msg_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (core_recv_req) begin
                    chan_d     = core_recv_chan;
                    persist_d  = persist_in;
                    rx_state_d = RX_REG;
                end
            end
            RX_REG: rx_state_d = RX_REG_CHK;
            RX_REG_CHK: begin
                if (!ccn_reg_ready) begin
                    status_d   = 2'd2;
                    rx_chan_d  = chan_q;
                    rx_msg_d   = 32'd0;
                    rx_state_d = RX_RESP;
                end else begin
                    timer_d    = 32'd0;
                    rx_state_d = RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (captured) begin
                    status_d   = 2'd0;
                    rx_chan_d  = ccn_recv_chan;
                    rx_msg_d   = ccn_recv_msg;
                    rx_state_d = persist_q ? RX_RESP : RX_UNREG;
                end else if (core_recv_cancel || timeout_hit) begin
                    status_d   = core_recv_cancel ? 2'd3 : 2'd1;
                    rx_chan_d  = chan_q;
                    rx_msg_d   = 32'd0;
                    rx_state_d = RX_UNREG;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            RX_UNREG: rx_state_d = RX_RESP;
            RX_RESP: begin
                if (core_rx_ready) begin
                    if (persist_q && status_q == 2'd0) begin
                        timer_d    = 32'd0;
                        rx_state_d = RX_WAIT;
                    end else begin
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q <= RX_IDLE;
            chan_q     <= '0;
            persist_q  <= 1'b0;
            timer_q    <= '0;
            status_q   <= '0;
            rx_chan_q  <= '0;
            rx_msg_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            chan_q     <= chan_d;
            persist_q  <= persist_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            rx_chan_q  <= rx_chan_d;
            rx_msg_q   <= rx_msg_d;
            if (ccn_recv_valid && !captured && drop_cnt_q != 16'hFFFF)
                drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign core_recv_busy  = (rx_state_q != RX_IDLE);
    assign ccn_reg_valid   = (rx_state_q == RX_REG);
    assign ccn_reg_chan    = ccn_reg_valid ? chan_q : 8'd0;
    assign ccn_unreg_valid = (rx_state_q == RX_UNREG);
    assign ccn_unreg_chan  = ccn_unreg_valid ? chan_q : 8'd0;
    assign ccn_recv_ready  = (rx_state_q == RX_WAIT);
    assign core_rx_valid   = (rx_state_q == RX_RESP);
    assign core_rx_chan    = rx_chan_q;
    assign core_rx_msg     = rx_msg_q;
    assign core_rx_status  = status_q;
    assign dbg_drop_count  = drop_cnt_q;
endmodule
